// File: rtl/tt_scan_driver_pkg.sv
// tt_scan_pkg: shared types and constants for the TinyTapeout scan-chain driver.
//   scan_state_e     - frame sequencer states
//   SCAN_BYTE_W      - width of the per-frame data byte
//   tt_scan_latency  - accept-to-out_valid distance in clk12MHz cycles
package tt_scan_pkg;

  localparam int SCAN_BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_LATCH,
    ST_WAIT,
    ST_CAP_SETUP,
    ST_CAP_CLK,
    ST_READOUT,
    ST_DONE
  } scan_state_e;

  // Accept happens in cycle 0; out_valid is high in the returned cycle.
  function automatic int tt_scan_latency(input int chain_bits, input int clk_div,
                                         input int design_wait);
    return 1 + 4 * chain_bits * clk_div + 3 * clk_div + design_wait;
  endfunction

endpackage

// File: rtl/tt_scan_driver_if.sv
// tt_scan_driver_if: byte request/response handshake plus the scan-chain lines.
//   master - driver side: accepts bytes, returns results, drives the chain
//   slave  - board/chain side: issues bytes, consumes results, returns chain data
interface tt_scan_driver_if;
  import tt_scan_pkg::*;

  logic                   in_valid;
  logic [SCAN_BYTE_W-1:0] in_data;
  logic                   in_ready;
  logic                   out_valid;
  logic [SCAN_BYTE_W-1:0] out_data;
  logic                   seg_latch;
  logic                   scan_clk;
  logic                   scan_data;
  logic                   scan_latch_en;
  logic                   scan_select;
  logic                   scan_data_ret;

  modport master (
    input  in_valid, in_data, scan_data_ret,
    output in_ready, out_valid, out_data, seg_latch,
           scan_clk, scan_data, scan_latch_en, scan_select
  );

  modport slave (
    output in_valid, in_data, scan_data_ret,
    input  in_ready, out_valid, out_data, seg_latch,
           scan_clk, scan_data, scan_latch_en, scan_select
  );
endinterface

// File: rtl/tt_scan_driver_phase_gen.sv
// tt_scan_phase_gen: CLK_DIV-cycle phase timer for the scan driver.
//   clk12MHz, reset - system clock, synchronous active-high reset
//   restart_i       - first cycle of the next state starts a fresh low phase
//   phase_end_o     - last cycle of the current CLK_DIV-cycle phase
//   sample_o        - last cycle of a low phase (just before scan_clk rises)
//   slot_end_o      - last cycle of a high phase (end of a bit slot)
//   hi_next_o       - high/low phase flag for the next cycle
module tt_scan_phase_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk12MHz,
  input  logic reset,
  input  logic restart_i,
  output logic phase_end_o,
  output logic sample_o,
  output logic slot_end_o,
  output logic hi_next_o
);
  localparam int CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          hi_q, hi_d;

  assign phase_end_o = (cnt_q == CNT_LAST);
  assign sample_o    = phase_end_o & ~hi_q;
  assign slot_end_o  = phase_end_o & hi_q;
  assign hi_next_o   = hi_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    hi_d  = hi_q;
    if (restart_i) begin
      cnt_d = '0;
      hi_d  = 1'b0;
    end else if (phase_end_o) begin
      cnt_d = '0;
      hi_d  = ~hi_q;
    end
  end

  always_ff @(posedge clk12MHz) begin
    if (reset) begin
      cnt_q <= '0;
      hi_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      hi_q  <= hi_d;
    end
  end
endmodule

// File: rtl/tt_scan_driver.sv
// tt_scan_driver: master end of the TinyTapeout scan chain (clk12MHz domain).
//   clk12MHz, reset - system clock, synchronous active-high reset
//   bus (master)    - in_valid/in_data/in_ready byte request,
//                     out_valid/out_data/seg_latch result,
//                     scan_clk/scan_data/scan_latch_en/scan_select to the chain,
//                     scan_data_ret from the chain end
// Each frame shifts one byte in, latches it, waits, captures the design
// outputs and shifts them back out. Every chain line comes straight from a
// flop, computed from the next state so it lines up with the state register.
module tt_scan_driver
  import tt_scan_pkg::*;
#(
  parameter int CHAIN_BITS  = 8,
  parameter int CLK_DIV     = 2,
  parameter int DESIGN_WAIT = 4
) (
  input  logic             clk12MHz,
  input  logic             reset,
  tt_scan_driver_if.master bus
);
  localparam int BW = $clog2(CHAIN_BITS + 1);
  localparam int WW = (DESIGN_WAIT > 0) ? $clog2(DESIGN_WAIT + 1) : 1;
  localparam logic [BW-1:0] BIT_LAST  = BW'(CHAIN_BITS - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'((DESIGN_WAIT > 0) ? DESIGN_WAIT - 1 : 0);

  scan_state_e state_q, state_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [CHAIN_BITS-1:0] tx_q, tx_d, rx_q, rx_d;
  logic [SCAN_BYTE_W-1:0] out_data_q, out_data_d;
  logic in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic scan_clk_q, scan_clk_d, scan_data_q, scan_data_d;
  logic latch_q, latch_d, select_q, select_d;
  logic restart, phase_end, sample, slot_end, hi_next;

  tt_scan_phase_gen #(.CLK_DIV(CLK_DIV)) u_phase (
    .clk12MHz   (clk12MHz),
    .reset      (reset),
    .restart_i  (restart),
    .phase_end_o(phase_end),
    .sample_o   (sample),
    .slot_end_o (slot_end),
    .hi_next_o  (hi_next)
  );

  // Every state starts with fresh phase/bit/wait counters.
  assign restart = (state_d != state_q);

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    wait_d  = wait_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          tx_d = '0;
          tx_d[CHAIN_BITS-1 -: SCAN_BYTE_W] = bus.in_data;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (slot_end) begin
          tx_d = tx_q << 1;
          if (bit_q == BIT_LAST) state_d = ST_LATCH;
          else bit_d = bit_q + BW'(1);
        end
      end
      ST_LATCH: begin
        if (phase_end) state_d = (DESIGN_WAIT == 0) ? ST_CAP_SETUP : ST_WAIT;
      end
      ST_WAIT: begin
        if (wait_q == WAIT_LAST) state_d = ST_CAP_SETUP;
        else wait_d = wait_q + WW'(1);
      end
      ST_CAP_SETUP: begin
        if (phase_end) state_d = ST_CAP_CLK;
      end
      ST_CAP_CLK: begin
        if (phase_end) state_d = ST_READOUT;
      end
      ST_READOUT: begin
        // First returned bit travels up to the MSB.
        if (sample) rx_d = {rx_q[CHAIN_BITS-2:0], bus.scan_data_ret};
        if (slot_end) begin
          if (bit_q == BIT_LAST) state_d = ST_DONE;
          else bit_d = bit_q + BW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (restart) begin
      bit_d  = '0;
      wait_d = '0;
    end
  end

  // Registered line values for the cycle the next state is presented.
  always_comb begin
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
    out_data_d  = out_data_q;
    if (state_d == ST_DONE) out_data_d = rx_q[CHAIN_BITS-1 -: SCAN_BYTE_W];
    scan_clk_d  = (((state_d == ST_SHIFT) || (state_d == ST_READOUT)) && hi_next)
                  || (state_d == ST_CAP_CLK);
    scan_data_d = (state_d == ST_SHIFT) ? tx_d[CHAIN_BITS-1] : 1'b0;
    latch_d     = (state_d == ST_LATCH);
    select_d    = (state_d == ST_CAP_SETUP) || (state_d == ST_CAP_CLK);
  end

  // ---- control and chain-line registers ----
  always_ff @(posedge clk12MHz) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      bit_q       <= '0;
      wait_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      scan_clk_q  <= 1'b0;
      scan_data_q <= 1'b0;
      latch_q     <= 1'b0;
      select_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_q       <= bit_d;
      wait_q      <= wait_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      scan_clk_q  <= scan_clk_d;
      scan_data_q <= scan_data_d;
      latch_q     <= latch_d;
      select_q    <= select_d;
    end
  end

  // ---- shift data registers ----
  always_ff @(posedge clk12MHz) begin
    tx_q <= tx_d;
    rx_q <= rx_d;
  end

  assign bus.in_ready      = in_ready_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.seg_latch     = out_valid_q;
  assign bus.out_data      = out_data_q;
  assign bus.scan_clk      = scan_clk_q;
  assign bus.scan_data     = scan_data_q;
  assign bus.scan_latch_en = latch_q;
  assign bus.scan_select   = select_q;
endmodule

// File: tb/tb_tt_scan_driver.sv
// Bench for tt_scan_driver: three driver instances, each with its own chain model.
//   inst 0: CHAIN_BITS=8,  CLK_DIV=2, DESIGN_WAIT=4, inverting design
//   inst 1: CHAIN_BITS=8,  CLK_DIV=1, DESIGN_WAIT=0, identity design
//   inst 2: CHAIN_BITS=16, CLK_DIV=2, DESIGN_WAIT=4, identity designs
module tb_tt_scan_driver;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst, iv, ir, ov, sl, sclk, sdat, lat, sel;
  logic [2:0][7:0] idat, od;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         inst;
    logic [7:0] data;
    int         due;
  } exp_t;
  exp_t sbq[$];
  int last_acc = 0;

  int pm_g = 0;
  int pm_rise = 0, pm_rise_sel = 0, pm_lat = 0, pm_sel = 0, pm_glitch = 0, pm_ovl = 0;
  logic [2:0] pclk = '0, pdat = '0;

  for (genvar g = 0; g < 3; g++) begin : gi
    localparam int CB  = (g == 2) ? 16 : 8;
    localparam int CD  = (g == 1) ? 1 : 2;
    localparam int DW  = (g == 1) ? 0 : 4;
    localparam bit INV = (g == 0);

    tt_scan_driver_if bus ();

    tt_scan_driver #(.CHAIN_BITS(CB), .CLK_DIV(CD), .DESIGN_WAIT(DW)) dut (
      .clk12MHz(clk),
      .reset   (rst[g]),
      .bus     (bus)
    );

    assign bus.in_valid = iv[g];
    assign bus.in_data  = idat[g];
    assign ir[g]   = bus.in_ready;
    assign ov[g]   = bus.out_valid;
    assign sl[g]   = bus.seg_latch;
    assign od[g]   = bus.out_data;
    assign sclk[g] = bus.scan_clk;
    assign sdat[g] = bus.scan_data;
    assign lat[g]  = bus.scan_latch_en;
    assign sel[g]  = bus.scan_select;

    // Chain model: shift toward scan_data_ret, parallel-load design outputs on select.
    logic [CB-1:0] ch, din;
    wire  [CB-1:0] dout = INV ? ~din : din;
    always @(posedge bus.scan_clk) ch <= bus.scan_select ? dout : {ch[CB-2:0], bus.scan_data};
    always @(posedge clk) if (bus.scan_latch_en) din <= ch;
    assign bus.scan_data_ret = ch[CB-1];
  end

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endfunction

  // Hand-computed accept-to-out_valid distances.
  function automatic int lat_of(input int g);
    return (g == 0) ? 75 : (g == 1) ? 36 : 139;
  endfunction

  // Scoreboard monitor plus protocol counters for instance pm_g.
  initial forever begin
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("seg_latch_eq_out_valid%0d", g), 32'(sl[g]), 32'(ov[g]));
      if (ov[g]) begin
        if (sbq.size() == 0) begin
          chk($sformatf("unexpected_out_valid%0d", g), 32'(ov[g]), 32'd0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("out_inst", 32'(g), 32'(e.inst));
          chk($sformatf("out_data%0d", g), 32'(od[g]), 32'(e.data));
          chk($sformatf("out_cycle%0d", g), 32'(cyc), 32'(e.due));
        end
      end
    end
    if (sclk[pm_g] && !pclk[pm_g]) begin
      if (sel[pm_g]) pm_rise_sel++;
      else pm_rise++;
    end
    if (lat[pm_g]) pm_lat++;
    if (sel[pm_g]) pm_sel++;
    if (lat[pm_g] && sel[pm_g]) pm_ovl++;
    if (sclk[pm_g] && (sdat[pm_g] !== pdat[pm_g])) pm_glitch++;
    pclk = sclk;
    pdat = sdat;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got time limit, expected bench completion");
    $fatal(1, "watchdog");
  end

  task automatic send(input int g, input logic [7:0] d, input logic [7:0] e, input bit expect_out);
    int n = 0;
    @(negedge clk);
    iv[g] = 1'b1;
    idat[g] = d;
    while (!ir[g] && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("accepted%0d", g), 32'(ir[g]), 32'd1);
    last_acc = cyc;
    if (ir[g] && expect_out) sbq.push_back('{g, e, cyc + lat_of(g)});
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sbq.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("frame_drained", 32'(sbq.size()), 32'd0);
    sbq.delete();
  endtask

  task automatic pm_clear(input int g);
    pm_g = g;
    pm_rise = 0; pm_rise_sel = 0; pm_lat = 0; pm_sel = 0; pm_glitch = 0; pm_ovl = 0;
  endtask

  task automatic pm_check(input int rises);
    chk("pm_scan_clk_rises", 32'(pm_rise), 32'(rises));
    chk("pm_capture_rises", 32'(pm_rise_sel), 32'd1);
    chk("pm_latch_cycles", 32'(pm_lat), 32'd2);
    chk("pm_select_cycles", 32'(pm_sel), 32'd4);
    chk("pm_data_change_clk_high", 32'(pm_glitch), 32'd0);
    chk("pm_latch_select_overlap", 32'(pm_ovl), 32'd0);
  endtask

  initial begin
    int acc1, n;
    rst  = '1;
    iv   = '0;
    idat = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("rst_in_ready%0d", g), 32'(ir[g]), 32'd0);
      chk($sformatf("rst_out_valid%0d", g), 32'(ov[g]), 32'd0);
      chk($sformatf("rst_out_data%0d", g), 32'(od[g]), 32'd0);
      chk($sformatf("rst_scan_lines%0d", g), 32'({sclk[g], sdat[g], lat[g], sel[g]}), 32'd0);
    end
    rst = '0;
    @(negedge clk);
    @(negedge clk);
    for (int g = 0; g < 3; g++) chk($sformatf("ready_after_rst%0d", g), 32'(ir[g]), 32'd1);

    // Inverting design, default timing, with protocol monitoring.
    pm_clear(0);
    send(0, 8'hA5, 8'h5A, 1'b1);
    @(negedge clk) iv[0] = 1'b0;
    wait_idle();
    pm_check(16);

    // Back-to-back frames on the fast identity instance.
    send(1, 8'h01, 8'h01, 1'b1);
    acc1 = last_acc;
    send(1, 8'h80, 8'h80, 1'b1);
    @(negedge clk) iv[1] = 1'b0;
    chk("b2b_accept_gap", 32'(last_acc - acc1), 32'd37);
    wait_idle();

    // 16-bit chain, identity designs.
    pm_clear(2);
    send(2, 8'hC3, 8'hC3, 1'b1);
    @(negedge clk) iv[2] = 1'b0;
    wait_idle();
    pm_check(32);

    // in_valid held for the whole frame, in_data changed mid-frame.
    send(0, 8'h0F, 8'hF0, 1'b1);
    acc1 = last_acc;
    n = 0;
    while (!ov[0] && n < 200) begin
      @(negedge clk);
      if (cyc == acc1 + 20) idat[0] = 8'hFF;
      n++;
    end
    iv[0] = 1'b0;
    wait_idle();
    repeat (90) @(negedge clk);

    // Reset during SHIFT aborts the frame.
    send(0, 8'hFF, 8'h00, 1'b0);
    acc1 = last_acc;
    @(negedge clk) iv[0] = 1'b0;
    while (cyc < acc1 + 10) @(negedge clk);
    rst[0] = 1'b1;
    @(negedge clk);
    chk("abort_scan_lines", 32'({sclk[0], sdat[0], lat[0], sel[0]}), 32'd0);
    chk("abort_out_valid", 32'(ov[0]), 32'd0);
    chk("abort_in_ready", 32'(ir[0]), 32'd0);
    rst[0] = 1'b0;
    repeat (100) @(negedge clk);
    chk("ready_after_abort", 32'(ir[0]), 32'd1);
    send(0, 8'h3C, 8'hC3, 1'b1);
    @(negedge clk) iv[0] = 1'b0;
    wait_idle();

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
